l1_cache_control: RTL and testbench
===================================

Name: l1_cache_control

Overview:
- Control FSM for the L1 cache: 2-way set-associative, 8 sets, write-back, write-allocate, 128-bit lines.
- Sequences the per-way data arrays, tag/valid/dirty arrays and per-set LRU bit in the cache datapath.
- Handshakes with the CPU memory port and the physical-memory port.
- Keeps saturating hit/miss performance counters.

Parameters:
CNT_WIDTH, 16, width of the hit_count and miss_count performance counters.

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
mem_resp  out  1  CPU request complete; one-cycle pulse
hit0  in  1  datapath: way0 valid and tag match
hit1  in  1  datapath: way1 valid and tag match
lru  in  1  datapath: LRU bit of the indexed set (victim way)
valid0/valid1  in  1 each  datapath: valid bits of the indexed set
dirty0/dirty1  in  1 each  datapath: dirty bits of the indexed set
load_data0/load_data1  out  1 each  write enable for way data array
load_tag0/load_tag1  out  1 each  write enable for way tag array
load_valid0/load_valid1  out  1 each  valid write enable; write value is always 1
load_dirty0/load_dirty1  out  1 each  dirty write enable
dirty_in  out  1  value written to the dirty bit
load_lru  out  1  LRU write enable
lru_in  out  1  LRU value written
datain_sel  out  1  0 = CPU-merged write data, 1 = line from pmem
pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag + index
way_sel  out  1  way driving the pmem write-back data mux
pmem_read  out  1  physical-memory read request
pmem_write  out  1  physical-memory write request
pmem_resp  in  1  physical memory done; one-cycle pulse
hit_count  out  CNT_WIDTH  saturating count of first-try hits
miss_count  out  CNT_WIDTH  saturating count of misses

Behaviour:
- State register: S_CHECK, S_WRITEBACK, S_ALLOCATE. Register victim: 1 bit. Register miss_pending: 1 bit.
- All control outputs are combinational decodes of state and inputs. Their default is 0.
- Reset, evaluated at the clock edge:
  - state goes to S_CHECK.
  - victim, miss_pending, hit_count and miss_count go to 0.
  - Reset overrides any transaction in flight, including an outstanding pmem request.
- S_CHECK, no request: all outputs 0; stay.
- S_CHECK, request with hit0 | hit1 (hit way h = hit1):
  - mem_resp = 1 in the same cycle (zero-wait hit).
  - load_lru = 1, lru_in = ~h.
  - On write: load_data_h = 1, datain_sel = 0, load_dirty_h = 1, dirty_in = 1.
  - hit_count increments if miss_pending = 0; miss_pending clears.
  - Stay in S_CHECK.
- S_CHECK, request with no hit:
  - victim <= lru; miss_pending <= 1.
  - miss_count increments, but only if miss_pending = 0, so each transaction counts at most one miss.
  - Next state is S_WRITEBACK if valid_lru & dirty_lru, else S_ALLOCATE.
- S_WRITEBACK:
  - Outputs: pmem_write = 1, pmem_addr_sel = 1, way_sel = victim.
  - Hold until pmem_resp, then go to S_ALLOCATE.
- S_ALLOCATE:
  - Outputs: pmem_read = 1, pmem_addr_sel = 0.
  - On pmem_resp, for the victim way: load_data = 1 with datain_sel = 1; load_tag = 1; load_valid = 1; load_dirty = 1 with dirty_in = 0. Then go to S_CHECK.
  - The retry in S_CHECK hits one cycle later. Miss latency = pmem latency(s) + 2 cycles.
- mem_read and mem_write both high: treat as a write.
- CPU drops its request mid-miss: the controller still completes the write-back/allocate, then idles in S_CHECK. miss_pending stays set and the next hit is not counted.
- hit0 & hit1 together is illegal (assertion). If it occurs, way0 takes priority.
- pmem_resp outside S_WRITEBACK/S_ALLOCATE is ignored.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.

Decomposition:
- lc3b_types carries:
  - enum l1_c_state_t {S_CHECK, S_WRITEBACK, S_ALLOCATE}
  - datain_sel and pmem_addr_sel encodings as named constants
  - the existing l1_c_index type
- One sub-module: sat_counter (parameter WIDTH; inputs clk, rst, inc; output count).
  - Instantiated twice, for hit_count and miss_count.

Test Plan:
1. Reset, then idle cycles: every output 0, counters 0; state S_CHECK shown by pmem_read = pmem_write = 0.
2. Read hit on way1 (hit1 = 1, lru = 1) → mem_resp = 1 the same cycle; load_lru = 1, lru_in = 0; hit_count = 1 the next cycle.
3. Read miss, clean victim (lru = 0, valid0 = 1, dirty0 = 0); pmem_resp after 3 cycles:
   - pmem_read asserted with pmem_addr_sel = 0.
   - On resp: load_data0 = load_tag0 = load_valid0 = 1, datain_sel = 1.
   - Next cycle (hit0 = 1): mem_resp = 1.
   - miss_count = 1, hit_count unchanged.
4. Write miss, dirty victim way1 (lru = 1, valid1 = dirty1 = 1):
   - S_WRITEBACK: pmem_write = 1, pmem_addr_sel = 1, way_sel = 1.
   - Then S_ALLOCATE and refill way1.
   - Retry hit: load_data1 = 1, load_dirty1 = 1, dirty_in = 1, datain_sel = 0.
5. Assert rst during S_ALLOCATE before pmem_resp → next cycle pmem_read = 0; state S_CHECK; counters 0; a subsequent hit responds in 1 cycle.
6. Force hit_count to 0xFFFE via 65534 hits, then 3 more hits → hit_count holds at 0xFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types and encodings for the L1 cache controller.
package lc3b_types;

    // Set index for the 8-set L1 cache.
    typedef logic [2:0] l1_c_index;

    // L1 control FSM states.
    typedef enum logic [1:0] {
        S_CHECK     = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } l1_c_state_t;

    // datain_sel encodings: source of data written into a way's data array.
    localparam logic DATAIN_CPU  = 1'b0;
    localparam logic DATAIN_PMEM = 1'b1;

    // pmem_addr_sel encodings: source of the physical-memory address.
    localparam logic PMEM_ADDR_CPU    = 1'b0;
    localparam logic PMEM_ADDR_VICTIM = 1'b1;

endpackage

// File: rtl/l1_cache_control_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/l1_cache_control.sv
// Control FSM for a 2-way, 8-set, write-back/write-allocate L1 cache.
module l1_cache_control
    import lc3b_types::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    // CPU side
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    // Datapath status
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 lru,
    input  logic                 valid0,
    input  logic                 valid1,
    input  logic                 dirty0,
    input  logic                 dirty1,
    // Datapath control
    output logic                 load_data0,
    output logic                 load_data1,
    output logic                 load_tag0,
    output logic                 load_tag1,
    output logic                 load_valid0,
    output logic                 load_valid1,
    output logic                 load_dirty0,
    output logic                 load_dirty1,
    output logic                 dirty_in,
    output logic                 load_lru,
    output logic                 lru_in,
    output logic                 datain_sel,
    output logic                 pmem_addr_sel,
    output logic                 way_sel,
    // Physical memory side
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    // Performance counters
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    l1_c_state_t state_q, state_d;
    logic        victim_q, victim_d;
    logic        miss_pending_q, miss_pending_d;
    logic        hit_inc, miss_inc;

    logic req, is_write, hit, hit_way, victim_dirty;

    assign req      = mem_read | mem_write;
    // A simultaneous read and write is handled as a write.
    assign is_write = mem_write;
    assign hit      = hit0 | hit1;
    // Way0 wins if both ways ever report a hit.
    assign hit_way  = ~hit0 & hit1;
    assign victim_dirty = lru ? (valid1 & dirty1) : (valid0 & dirty0);

    // Next-state and control-output decode.
    always_comb begin
        state_d        = state_q;
        victim_d       = victim_q;
        miss_pending_d = miss_pending_q;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        mem_resp       = 1'b0;
        load_data0     = 1'b0;
        load_data1     = 1'b0;
        load_tag0      = 1'b0;
        load_tag1      = 1'b0;
        load_valid0    = 1'b0;
        load_valid1    = 1'b0;
        load_dirty0    = 1'b0;
        load_dirty1    = 1'b0;
        dirty_in       = 1'b0;
        load_lru       = 1'b0;
        lru_in         = 1'b0;
        datain_sel     = DATAIN_CPU;
        pmem_addr_sel  = PMEM_ADDR_CPU;
        way_sel        = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;

        unique case (state_q)
            S_CHECK: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hit_way;
                        if (is_write) begin
                            datain_sel = DATAIN_CPU;
                            dirty_in   = 1'b1;
                            if (hit_way) begin
                                load_data1  = 1'b1;
                                load_dirty1 = 1'b1;
                            end else begin
                                load_data0  = 1'b1;
                                load_dirty0 = 1'b1;
                            end
                        end
                        // The retry hit after a refill is not a first-try hit.
                        hit_inc        = ~miss_pending_q;
                        miss_pending_d = 1'b0;
                    end else begin
                        victim_d       = lru;
                        miss_pending_d = 1'b1;
                        miss_inc       = ~miss_pending_q;
                        state_d        = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = PMEM_ADDR_VICTIM;
                way_sel       = victim_q;
                if (pmem_resp) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = PMEM_ADDR_CPU;
                if (pmem_resp) begin
                    datain_sel = DATAIN_PMEM;
                    dirty_in   = 1'b0;
                    if (victim_q) begin
                        load_data1  = 1'b1;
                        load_tag1   = 1'b1;
                        load_valid1 = 1'b1;
                        load_dirty1 = 1'b1;
                    end else begin
                        load_data0  = 1'b1;
                        load_tag0   = 1'b1;
                        load_valid0 = 1'b1;
                        load_dirty0 = 1'b1;
                    end
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_CHECK;
            end
        endcase
    end

    // State, victim and miss-pending registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_CHECK;
            victim_q       <= 1'b0;
            miss_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            victim_q       <= victim_d;
            miss_pending_q <= miss_pending_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

    // Both ways matching the same tag means the arrays are corrupt.
    assert property (@(posedge clk) disable iff (rst) !(hit0 && hit1))
        else $error("hit0 and hit1 asserted together");

endmodule

// File: tb/tb_l1_cache_control.sv
// Scoreboard bench for l1_cache_control: expected CPU responses are queued by
// the stimulus and checked by a monitor whenever mem_resp is presented.
module tb_l1_cache_control;

    localparam int unsigned CNT_WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic mem_read, mem_write, mem_resp;
    logic hit0, hit1, lru, valid0, valid1, dirty0, dirty1;
    logic load_data0, load_data1, load_tag0, load_tag1;
    logic load_valid0, load_valid1, load_dirty0, load_dirty1;
    logic dirty_in, load_lru, lru_in, datain_sel, pmem_addr_sel, way_sel;
    logic pmem_read, pmem_write, pmem_resp;
    logic [CNT_WIDTH-1:0] hit_count, miss_count;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    l1_cache_control #(
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_resp      (mem_resp),
        .hit0          (hit0),
        .hit1          (hit1),
        .lru           (lru),
        .valid0        (valid0),
        .valid1        (valid1),
        .dirty0        (dirty0),
        .dirty1        (dirty1),
        .load_data0    (load_data0),
        .load_data1    (load_data1),
        .load_tag0     (load_tag0),
        .load_tag1     (load_tag1),
        .load_valid0   (load_valid0),
        .load_valid1   (load_valid1),
        .load_dirty0   (load_dirty0),
        .load_dirty1   (load_dirty1),
        .dirty_in      (dirty_in),
        .load_lru      (load_lru),
        .lru_in        (lru_in),
        .datain_sel    (datain_sel),
        .pmem_addr_sel (pmem_addr_sel),
        .way_sel       (way_sel),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_resp     (pmem_resp),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // Snapshot of every control output:
    // {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, ctl[11:0]}
    // ctl = {load_lru, lru_in, load_data0, load_data1, load_dirty0, load_dirty1,
    //        dirty_in, datain_sel, load_tag0, load_tag1, load_valid0, load_valid1}
    function automatic logic [16:0] cur_out();
        return {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
                load_lru, lru_in, load_data0, load_data1, load_dirty0, load_dirty1,
                dirty_in, datain_sel, load_tag0, load_tag1, load_valid0, load_valid1};
    endfunction

    function automatic logic [16:0] ov(input logic resp, input logic pr, input logic pw,
                                       input logic pas, input logic ws,
                                       input logic [11:0] c);
        return {resp, pr, pw, pas, ws, c};
    endfunction

    // Expected controls for a hit on 'way'.
    function automatic logic [11:0] hit_ctl(input logic way, input logic wr);
        logic [11:0] c;
        c     = '0;
        c[11] = 1'b1;
        c[10] = ~way;
        if (wr) begin
            if (way) begin
                c[8] = 1'b1;
                c[6] = 1'b1;
            end else begin
                c[9] = 1'b1;
                c[7] = 1'b1;
            end
            c[5] = 1'b1;
        end
        return c;
    endfunction

    // Expected controls on the refill cycle into 'way'.
    function automatic logic [11:0] fill_ctl(input logic way);
        logic [11:0] c;
        c    = '0;
        c[4] = 1'b1;
        if (way) begin
            c[8] = 1'b1;
            c[6] = 1'b1;
            c[2] = 1'b1;
            c[0] = 1'b1;
        end else begin
            c[9] = 1'b1;
            c[7] = 1'b1;
            c[3] = 1'b1;
            c[1] = 1'b1;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic push(input string name, input logic [16:0] v);
        exp_q.push_back(v);
        name_q.push_back(name);
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        lru       = 1'b0;
        valid0    = 1'b0;
        valid1    = 1'b0;
        dirty0    = 1'b0;
        dirty1    = 1'b0;
        pmem_resp = 1'b0;
    endtask

    // Monitor: every mem_resp pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_resp === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_resp: got outputs 0x%0h, expected no mem_resp",
                         cur_out());
            end else begin
                automatic logic [16:0] e = exp_q.pop_front();
                automatic string       n = name_q.pop_front();
                if (cur_out() !== e) begin
                    miscompares++;
                    $display("FAIL %s: got outputs 0x%0h, expected 0x%0h", n, cur_out(), e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;

        // 1. Reset and idle.
        step();
        at_sample();
        chk("idle_outputs", 32'(cur_out()), 32'h0);
        chk("reset_hit_count", 32'(hit_count), 32'h0);
        chk("reset_miss_count", 32'(miss_count), 32'h0);

        // 2. Read hit on way1.
        step();
        mem_read = 1'b1; hit1 = 1'b1; lru = 1'b1;
        push("read_hit_way1", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hit_ctl(1'b1, 1'b0)));
        step();
        idle_inputs();
        at_sample();
        chk("hit_count_after_hit", 32'(hit_count), 32'h1);

        // 3. Read miss, clean victim way0, pmem responds on the third cycle.
        step();
        mem_read = 1'b1; lru = 1'b0; valid0 = 1'b1; dirty0 = 1'b0;
        at_sample();
        chk("miss_detect_outputs", 32'(cur_out()), 32'h0);
        step();
        at_sample();
        chk("alloc_wait1", 32'(cur_out()), 32'(ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0)));
        step();
        at_sample();
        chk("alloc_wait2", 32'(cur_out()), 32'(ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0)));
        step();
        pmem_resp = 1'b1;
        at_sample();
        chk("alloc_fill_way0", 32'(cur_out()),
            32'(ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, fill_ctl(1'b0))));
        step();
        pmem_resp = 1'b0; hit0 = 1'b1;
        push("retry_hit_way0", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hit_ctl(1'b0, 1'b0)));
        step();
        idle_inputs();
        at_sample();
        chk("miss_count_clean_miss", 32'(miss_count), 32'h1);
        chk("hit_count_unchanged", 32'(hit_count), 32'h1);

        // 4. Write miss, dirty victim way1.
        step();
        mem_write = 1'b1; lru = 1'b1; valid1 = 1'b1; dirty1 = 1'b1;
        step();
        at_sample();
        chk("writeback_1", 32'(cur_out()), 32'(ov(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0)));
        step();
        pmem_resp = 1'b1;
        at_sample();
        chk("writeback_resp", 32'(cur_out()), 32'(ov(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0)));
        step();
        pmem_resp = 1'b0;
        at_sample();
        chk("alloc_after_wb", 32'(cur_out()), 32'(ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0)));
        step();
        pmem_resp = 1'b1;
        at_sample();
        chk("alloc_fill_way1", 32'(cur_out()),
            32'(ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, fill_ctl(1'b1))));
        step();
        pmem_resp = 1'b0; hit1 = 1'b1;
        push("retry_write_hit_way1", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hit_ctl(1'b1, 1'b1)));
        step();
        idle_inputs();
        at_sample();
        chk("miss_count_dirty_miss", 32'(miss_count), 32'h2);
        chk("hit_count_after_dirty", 32'(hit_count), 32'h1);

        // 5. Reset during allocate.
        step();
        mem_read = 1'b1; lru = 1'b0; valid0 = 1'b1;
        step();
        at_sample();
        chk("alloc_before_reset", 32'(pmem_read), 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        at_sample();
        chk("after_reset_outputs", 32'(cur_out()), 32'h0);
        chk("after_reset_hit_count", 32'(hit_count), 32'h0);
        chk("after_reset_miss_count", 32'(miss_count), 32'h0);
        step();
        mem_read = 1'b1; hit0 = 1'b1; lru = 1'b0;
        push("hit_after_reset", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hit_ctl(1'b0, 1'b0)));
        step();
        idle_inputs();
        at_sample();
        chk("hit_counted_after_reset", 32'(hit_count), 32'h1);

        // Read and write together behave as a write.
        mem_read = 1'b1; mem_write = 1'b1; hit0 = 1'b1; lru = 1'b1;
        push("rw_both_is_write", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hit_ctl(1'b0, 1'b1)));
        step();
        idle_inputs();
        at_sample();
        chk("hit_count_rw", 32'(hit_count), 32'h2);

        // 6. Saturation of hit_count.
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_read = 1'b1; hit0 = 1'b1; lru = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            push("bulk_hit", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hit_ctl(1'b0, 1'b0)));
            step();
        end
        idle_inputs();
        at_sample();
        chk("hit_count_fffe", 32'(hit_count), 32'hFFFE);
        step();
        mem_read = 1'b1; hit0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("sat_hit", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hit_ctl(1'b0, 1'b0)));
            step();
        end
        idle_inputs();
        at_sample();
        chk("hit_count_saturated", 32'(hit_count), 32'hFFFF);
        chk("miss_count_zero_sat", 32'(miss_count), 32'h0);

        step();
        at_sample();
        chk("all_responses_seen", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
